// File: rtl/exec_pkg.sv
// Shared definitions for the EX stage: ALU opcodes, ID/EX and EX/MEM field
// positions, the bubble constant and the single-cycle ALU function.
package exec_pkg;

  // aluOp encodings
  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_MUL  = 4'h8;
  localparam logic [3:0] ALU_DIVU = 4'h9;
  localparam logic [3:0] ALU_REMU = 4'hA;
  localparam logic [3:0] ALU_NOR  = 4'hC;

  // ID/EX bundle layout
  localparam int IDEX_W         = 121;
  localparam int IDEX_RD1_LSB   = 0;
  localparam int IDEX_RD2_LSB   = 32;
  localparam int IDEX_IMM_LSB   = 64;
  localparam int IDEX_RT_LSB    = 96;
  localparam int IDEX_RD_LSB    = 101;
  localparam int IDEX_ALUOP_LSB = 106;
  localparam int IDEX_ALUSRC    = 110;
  localparam int IDEX_REGDST    = 111;
  localparam int IDEX_CTRL_LSB  = 112;  // MemRead, MemToReg, MemWrite, RegWrite
  localparam int IDEX_RS_LSB    = 116;

  // EX/MEM bundle layout
  localparam int EXMEM_W         = 75;
  localparam int EXMEM_RES_LSB   = 0;
  localparam int EXMEM_STORE_LSB = 32;
  localparam int EXMEM_WREG_LSB  = 64;
  localparam int EXMEM_MEMREAD   = 71;
  localparam int EXMEM_MEMTOREG  = 72;
  localparam int EXMEM_MEMWRITE  = 73;
  localparam int EXMEM_REGWRITE  = 74;

  localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE = 75'b0;

  // Mul/div unit operation select (low two bits of the aluOp code)
  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_e;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
      ALU_NOR: return ~(a | b);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_iter_muldiv.sv
// Iterative multiply / unsigned divide unit: one shift-add or restoring
// shift-subtract step per clock. done and result are combinational on the
// final iteration so the caller can register the result on that same edge.
module iter_muldiv
  import exec_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(MD_CYCLES);

  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  // acc: product / partial remainder; x: multiplicand / dividend->quotient;
  // y: multiplier / divisor
  logic [XLEN-1:0] acc, x, y;
  logic [XLEN-1:0] acc_nxt, x_nxt, y_nxt;
  logic [XLEN:0]   trial, diff;

  // One iteration of the selected algorithm
  always_comb begin
    trial   = {acc, x[XLEN-1]};
    diff    = trial - {1'b0, y};
    acc_nxt = acc;
    x_nxt   = x;
    y_nxt   = y;
    if (op_q == MD_MUL) begin
      acc_nxt = acc + (y[0] ? x : '0);
      x_nxt   = x << 1;
      y_nxt   = y >> 1;
    end else if (!diff[XLEN]) begin
      acc_nxt = diff[XLEN-1:0];
      x_nxt   = {x[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = trial[XLEN-1:0];
      x_nxt   = {x[XLEN-2:0], 1'b0};
    end
    result = (op_q == MD_DIVU) ? x_nxt : acc_nxt;
    done   = busy && (cnt == CW'(MD_CYCLES - 1));
  end

  // Operand load, iteration counter and shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      acc  <= '0;
      x    <= '0;
      y    <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      op_q <= op;
      acc  <= '0;
      x    <= a;
      y    <= b;
    end else if (busy) begin
      acc <= acc_nxt;
      x   <= x_nxt;
      y   <= y_nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: single-cycle ALU, iterative mul/div, EX/MEM register and
// decode stall. Define EXEC_FWD_EN to forward the EX/MEM ALU result into
// operand A and readData2 when the register indices match.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDEX_W-1:0]   IDEXReg,
  input  logic                idexValid,
  output logic [EXMEM_W-1:0]  EXMEMReg,
  output logic                stall
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t state;

  logic [31:0] rd1_in, rd2_in, imm, rd1, rd2, opb, alu_res, md_result;
  logic [4:0]  rt, rd, rs, wreg, hold_wreg;
  logic [3:0]  alu_op, ctrl, hold_ctrl;
  logic [31:0] hold_store;
  logic        alu_src, reg_dst, start, md_busy, md_done;

  assign rd1_in  = IDEXReg[IDEX_RD1_LSB +: 32];
  assign rd2_in  = IDEXReg[IDEX_RD2_LSB +: 32];
  assign imm     = IDEXReg[IDEX_IMM_LSB +: 32];
  assign rt      = IDEXReg[IDEX_RT_LSB +: 5];
  assign rd      = IDEXReg[IDEX_RD_LSB +: 5];
  assign rs      = IDEXReg[IDEX_RS_LSB +: 5];
  assign alu_op  = IDEXReg[IDEX_ALUOP_LSB +: 4];
  assign alu_src = IDEXReg[IDEX_ALUSRC];
  assign reg_dst = IDEXReg[IDEX_REGDST];
  assign ctrl    = IDEXReg[IDEX_CTRL_LSB +: 4];

`ifdef EXEC_FWD_EN
  logic fwd_ok;
  assign fwd_ok = EXMEMReg[EXMEM_REGWRITE] && (EXMEMReg[EXMEM_WREG_LSB +: 5] != 5'd0)
                  && !EXMEMReg[EXMEM_MEMREAD];
  assign rd1 = (fwd_ok && rs == EXMEMReg[EXMEM_WREG_LSB +: 5]) ?
               EXMEMReg[EXMEM_RES_LSB +: 32] : rd1_in;
  assign rd2 = (fwd_ok && rt == EXMEMReg[EXMEM_WREG_LSB +: 5]) ?
               EXMEMReg[EXMEM_RES_LSB +: 32] : rd2_in;
`else
  logic unused_rs;
  assign unused_rs = ^rs;
  assign rd1 = rd1_in;
  assign rd2 = rd2_in;
`endif

  assign opb     = alu_src ? imm : rd2;
  assign wreg    = reg_dst ? rd : rt;
  assign alu_res = alu_calc(alu_op, rd1, opb);
  assign stall   = (state == S_BUSY);
  assign start   = (state == S_IDLE) && idexValid && is_multi(alu_op);

  iter_muldiv #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (alu_op[1:0]),
    .a      (rd1),
    .b      (opb),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // FSM, EX/MEM register and latched controls of the in-flight mul/div
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      EXMEMReg   <= EXMEM_BUBBLE;
      hold_ctrl  <= '0;
      hold_wreg  <= '0;
      hold_store <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idexValid && is_multi(alu_op)) begin
            state      <= S_BUSY;
            EXMEMReg   <= EXMEM_BUBBLE;
            hold_ctrl  <= ctrl;
            hold_wreg  <= wreg;
            hold_store <= rd2;
          end else if (idexValid) begin
            EXMEMReg <= {ctrl, 2'b00, wreg, rd2, alu_res};
          end else begin
            EXMEMReg <= EXMEM_BUBBLE;
          end
        end
        S_BUSY: begin
          if (md_done) begin
            EXMEMReg <= {hold_ctrl, 2'b00, hold_wreg, hold_store, md_result};
            state    <= S_IDLE;
          end else begin
            EXMEMReg <= EXMEM_BUBBLE;
            // The unit is never idle while BUSY; recover rather than hang
            if (!md_busy) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed steps, expected EX/MEM
// words queued at drive time and compared one per clock.
module tb_execute_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [120:0] IDEXReg = '0;
  logic         idexValid = 1'b0;
  logic [74:0]  EXMEMReg;
  logic         stall;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  string       cur_tag = "init";
  logic [74:0] sb[$];

  localparam logic [3:0] CT_NONE = 4'b0000;
  localparam logic [3:0] CT_RW   = 4'b1000;
  localparam logic [3:0] CT_SW   = 4'b0100;
  localparam logic [3:0] CT_LW   = 4'b1011;
  localparam logic [74:0] BUB = '0;

  execute_stage dut (
    .clk       (clk),
    .rst       (rst),
    .IDEXReg   (IDEXReg),
    .idexValid (idexValid),
    .EXMEMReg  (EXMEMReg),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [120:0] mk_idex(input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [3:0] op, input logic alusrc, input logic regdst,
      input logic [3:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
      input logic [31:0] imm);
    return {rs, ctrl, regdst, alusrc, op, rd, rt, imm, rd2, rd1};
  endfunction

  function automatic logic [74:0] mk_exm(input logic [3:0] ctrl, input logic [4:0] wreg,
      input logic [31:0] store, input logic [31:0] res);
    return {ctrl, 2'b00, wreg, store, res};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h6: return a - b;
      4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: return ~(a | b);
      4'h8: return a * b;
      4'h9: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hA: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [74:0] got, input logic [74:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [120:0] idex, input logic valid);
    IDEXReg   = idex;
    idexValid = valid;
  endtask

  // Advance one edge, then pop and compare the EX/MEM word and stall
  task automatic tick(input logic exp_stall);
    logic [74:0] exp;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s sb_empty: observed %h expected none", cur_tag, EXMEMReg);
    end else begin
      exp = sb.pop_front();
      chk({cur_tag, " exmem"}, EXMEMReg, exp);
    end
    chk({cur_tag, " stall"}, {74'd0, stall}, {74'd0, exp_stall});
  endtask

  task automatic step(input string tag, input logic [120:0] idex, input logic valid,
                      input logic [74:0] exp);
    cur_tag = tag;
    drive(idex, valid);
    sb.push_back(exp);
    tick(1'b0);
  endtask

  // Issue a mul/div op, present the next instruction while stalled
  task automatic multi(input string tag, input logic [120:0] idex, input logic [74:0] exp,
                       input logic [120:0] nxt, input logic nxt_valid);
    cur_tag = tag;
    drive(idex, 1'b1);
    sb.push_back(BUB);
    tick(1'b1);
    drive(nxt, nxt_valid);
    repeat (31) begin
      sb.push_back(BUB);
      tick(1'b1);
    end
    sb.push_back(exp);
    tick(1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk({tag, " exmem"}, EXMEMReg, BUB);
    chk({tag, " stall"}, {74'd0, stall}, 75'd0);
    drive('0, 1'b0);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [120:0] nop_add, iv;
    logic [3:0]   ops[6];
    logic [3:0]   mops[3];
    logic [31:0]  a, b;
    logic [3:0]   op;
    ops  = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
    mops = '{4'h8, 4'h9, 4'hA};

    #1 chk("reset exmem", EXMEMReg, BUB);
    chk("reset stall", {74'd0, stall}, 75'd0);
    repeat (2) @(posedge clk);
    #6 rst = 1'b0;

    // Single-cycle ALU
    step("add_wrap", mk_idex(0, 0, 5, 4'h2, 0, 1, CT_RW, 32'h7FFF_FFFF, 32'h1, 0), 1,
         mk_exm(CT_RW, 5, 32'h1, 32'h8000_0000));
    step("slt", mk_idex(0, 0, 0, 4'h7, 0, 0, CT_NONE, 32'hFFFF_FFFF, 32'h1, 0), 1,
         mk_exm(CT_NONE, 0, 32'h1, 32'h1));
    step("sub_wrap", mk_idex(0, 0, 0, 4'h6, 0, 0, CT_NONE, 32'h0, 32'h1, 0), 1,
         mk_exm(CT_NONE, 0, 32'h1, 32'hFFFF_FFFF));
    step("sw", mk_idex(0, 0, 0, 4'h2, 1, 0, CT_SW, 32'h100, 32'hABCD, 32'h8), 1,
         mk_exm(CT_SW, 0, 32'hABCD, 32'h108));
    step("and", mk_idex(0, 0, 0, 4'h0, 0, 0, CT_NONE, 32'hF0F0_1234, 32'h0FF0_FF00, 0), 1,
         mk_exm(CT_NONE, 0, 32'h0FF0_FF00, 32'h00F0_1200));
    step("or_imm", mk_idex(0, 0, 0, 4'h1, 1, 0, CT_NONE, 32'h1200_0000, 32'h5, 32'h34), 1,
         mk_exm(CT_NONE, 0, 32'h5, 32'h1200_0034));
    step("nor", mk_idex(0, 0, 0, 4'hC, 0, 0, CT_NONE, 32'h0000_FFFF, 32'h00FF_0000, 0), 1,
         mk_exm(CT_NONE, 0, 32'h00FF_0000, 32'hFF00_0000));
    step("undef_op", mk_idex(0, 9, 7, 4'hF, 0, 1, 4'b1001, 32'h55, 32'h66, 0), 1,
         mk_exm(4'b1001, 7, 32'h66, 32'h0));
    step("bubble", mk_idex(0, 0, 5, 4'h2, 0, 1, CT_RW, 32'h1, 32'h1, 0), 0, BUB);
    step("pre_rst", mk_idex(0, 0, 5, 4'h2, 0, 1, CT_RW, 32'h10, 32'h20, 0), 1,
         mk_exm(CT_RW, 5, 32'h20, 32'h30));
    async_reset("rst_midrun");
    step("post_rst", '0, 0, BUB);

    for (int i = 0; i < 6; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = ops[$urandom_range(0, 5)];
      step("rand_alu", mk_idex(0, 0, 0, op, 0, 0, CT_NONE, a, b, 0), 1,
           mk_exm(CT_NONE, 0, b, ref_alu(op, a, b)));
    end

    // MUL with a held ADD accepted one edge after the result
    nop_add = mk_idex(0, 0, 6, 4'h2, 0, 1, CT_RW, 32'd10, 32'd20, 0);
    multi("mul", mk_idex(0, 0, 4, 4'h8, 0, 1, CT_RW, 32'h0001_2345, 32'h0001_0000, 0),
          mk_exm(CT_RW, 4, 32'h0001_0000, 32'h2345_0000), nop_add, 1);
    step("held_add", nop_add, 1, mk_exm(CT_RW, 6, 32'd20, 32'd30));

    // Reset in the middle of a divide: nothing may come out afterwards
    cur_tag = "div_rst";
    drive(mk_idex(0, 0, 8, 4'h9, 0, 1, CT_RW, 32'd100, 32'd7, 0), 1);
    sb.push_back(BUB);
    tick(1'b1);
    repeat (10) begin
      sb.push_back(BUB);
      tick(1'b1);
    end
    async_reset("rst_busy");
    repeat (36) begin
      sb.push_back(BUB);
      tick(1'b0);
    end

    // Back-to-back divides, then divide by zero
    iv = mk_idex(0, 0, 9, 4'hA, 0, 1, CT_RW, 32'd100, 32'd7, 0);
    multi("divu", mk_idex(0, 0, 8, 4'h9, 0, 1, CT_RW, 32'd100, 32'd7, 0),
          mk_exm(CT_RW, 8, 32'd7, 32'd14), iv, 1);
    multi("remu", iv, mk_exm(CT_RW, 9, 32'd7, 32'd2), '0, 0);
    iv = mk_idex(0, 0, 11, 4'hA, 0, 1, CT_RW, 32'd5, 32'd0, 0);
    multi("divu_0", mk_idex(0, 0, 10, 4'h9, 0, 1, CT_RW, 32'd5, 32'd0, 0),
          mk_exm(CT_RW, 10, 32'd0, 32'hFFFF_FFFF), iv, 1);
    multi("remu_0", iv, mk_exm(CT_RW, 11, 32'd0, 32'd5), nop_add, 1);
    step("after_div", nop_add, 1, mk_exm(CT_RW, 6, 32'd20, 32'd30));

    for (int i = 0; i < 3; i++) begin
      a  = $urandom;
      b  = $urandom_range(1, 70000);
      op = mops[$urandom_range(0, 2)];
      multi("rand_md", mk_idex(0, 0, 0, op, 0, 0, CT_NONE, a, b, 0),
            mk_exm(CT_NONE, 0, b, ref_alu(op, a, b)), '0, 0);
    end

    // Forwarding from EX/MEM
    step("fwd_src", mk_idex(1, 2, 3, 4'h2, 0, 1, CT_RW, 32'd2, 32'd3, 0), 1,
         mk_exm(CT_RW, 3, 32'd3, 32'd5));
`ifdef EXEC_FWD_EN
    step("fwd_use", mk_idex(3, 0, 4, 4'h2, 0, 1, CT_RW, 32'd0, 32'd1, 0), 1,
         mk_exm(CT_RW, 4, 32'd1, 32'd6));
`else
    step("fwd_use", mk_idex(3, 0, 4, 4'h2, 0, 1, CT_RW, 32'd0, 32'd1, 0), 1,
         mk_exm(CT_RW, 4, 32'd1, 32'd1));
`endif
    step("fwd_src2", mk_idex(1, 2, 3, 4'h2, 0, 1, CT_RW, 32'd2, 32'd3, 0), 1,
         mk_exm(CT_RW, 3, 32'd3, 32'd5));
`ifdef EXEC_FWD_EN
    step("fwd_store", mk_idex(0, 3, 0, 4'h2, 1, 0, CT_SW, 32'h100, 32'hDEAD, 32'h4), 1,
         mk_exm(CT_SW, 3, 32'd5, 32'h104));
`else
    step("fwd_store", mk_idex(0, 3, 0, 4'h2, 1, 0, CT_SW, 32'h100, 32'hDEAD, 32'h4), 1,
         mk_exm(CT_SW, 3, 32'hDEAD, 32'h104));
`endif
    step("fwd_r0_src", mk_idex(1, 2, 0, 4'h2, 0, 1, CT_RW, 32'd2, 32'd3, 0), 1,
         mk_exm(CT_RW, 0, 32'd3, 32'd5));
    step("fwd_r0_use", mk_idex(0, 0, 4, 4'h2, 0, 1, CT_RW, 32'd0, 32'd1, 0), 1,
         mk_exm(CT_RW, 4, 32'd1, 32'd1));
    step("fwd_ld_src", mk_idex(1, 2, 3, 4'h2, 0, 1, CT_LW, 32'd2, 32'd3, 0), 1,
         mk_exm(CT_LW, 3, 32'd3, 32'd5));
    step("fwd_ld_use", mk_idex(3, 0, 4, 4'h2, 0, 1, CT_RW, 32'd0, 32'd1, 0), 1,
         mk_exm(CT_RW, 4, 32'd1, 32'd1));
    step("tail", '0, 0, BUB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
